// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_N_REQ   = 4;
    localparam int UART_D_WIDTH = 8;
    localparam int UART_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int GW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last_grant,
    output logic             any,
    output logic [GW-1:0]    winner
);

    always_comb begin
        int  idx;
        logic found;
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req[idx]) begin
                winner = idx[GW-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ requesters.
// Optional START watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int N_REQ   = UART_N_REQ,
    parameter int D_WIDTH = UART_D_WIDTH,
    parameter int TIMEOUT = UART_TIMEOUT,
    localparam int GW     = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [D_WIDTH-1:0]         TX_data,
    output logic                       transmit,
    input  logic                       busy,
    output logic [GW-1:0]              grant_id,
`ifdef UART_ARB_TIMEOUT_EN
    output logic                       timeout_err,
`endif
    output logic                       active
);

    state_t             state_q, state_d;
    logic [D_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic               any;
    logic [GW-1:0]      winner;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .any        (any),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            req_ready_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            req_ready_q  <= req_ready_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Requester inputs are only looked at in IDLE; the grant latches everything needed for the transfer.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        req_ready_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any && !busy) begin
                    state_d             = START;
                    tx_data_d           = req_data[winner*D_WIDTH +: D_WIDTH];
                    grant_id_d          = winner;
                    last_grant_d        = winner;
                    req_ready_d[winner] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d               = '0;
`endif
                end
            end
            START: begin
                if (busy) begin
                    state_d = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            SEND: begin
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        transmit  = (state_q == START);
        active    = (state_q != IDLE);
        req_ready = req_ready_q;
        TX_data   = tx_data_q;
        grant_id  = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_err = timeout_err_q;
`endif
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, D_WIDTH=8).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  TX_data;
    logic        transmit;
    logic        busy;
    logic [1:0]  grant_id;
    logic        active;
`ifdef UART_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .N_REQ   (4),
        .D_WIDTH (8)
`ifdef UART_ARB_TIMEOUT_EN
        , .TIMEOUT (16)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .TX_data     (TX_data),
        .transmit    (transmit),
        .busy        (busy),
        .grant_id    (grant_id),
`ifdef UART_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid_in, input logic busy_in);
        req_valid = valid_in;
        busy      = busy_in;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an accept pulse, then check the latched grant.
    task automatic waitGrant(input string tag, input logic [1:0] exp_id);
        logic [7:0] exp_data;
        exp_data = 8'h41 + 8'(exp_id);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_ready != 4'b0000) break;
        end
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << exp_id));
        checkOutput({tag, "_id"},    32'(grant_id),  32'(exp_id));
        checkOutput({tag, "_data"},  32'(TX_data),   32'(exp_data));
        checkOutput({tag, "_tx"},    32'(transmit),  32'd1);
    endtask

    task automatic completeTxn(input string tag);
        busy = 1'b1;
        tick();
        checkOutput({tag, "_send_tx"},  32'(transmit), 32'd0);
        checkOutput({tag, "_send_act"}, 32'(active),   32'd1);
        busy = 1'b0;
        tick();
        checkOutput({tag, "_idle"}, 32'(active), 32'd0);
    endtask

    initial begin
        int grants;
        int dly;
        int hold;
        logic [1:0] exp_order [5];
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst      = 1'b0;
        req_data = {8'h44, 8'h43, 8'h42, 8'h41};
        applyStimulus(4'b1111, 1'b0);

        // Reset: no accept pulses while held low.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_ready", 32'(req_ready), 32'd0);
        end
        checkOutput("rst_tx",     32'(transmit), 32'd0);
        checkOutput("rst_active", 32'(active),   32'd0);
        checkOutput("rst_data",   32'(TX_data),  32'd0);
        checkOutput("rst_id",     32'(grant_id), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
        checkOutput("rst_terr",   32'(timeout_err), 32'd0);
`endif

        // Round robin with a modelled transmitter: busy 2 cycles after transmit, high 10 cycles.
        rst    = 1'b1;
        grants = 0;
        dly    = -1;
        hold   = 0;
        for (int cyc = 0; cyc < 300 && grants < 5; cyc++) begin
            tick();
            if (req_ready != 4'b0000) begin
                checkOutput("rr_id",    32'(grant_id),  32'(exp_order[grants]));
                checkOutput("rr_data",  32'(TX_data),   32'(8'h41 + 8'(exp_order[grants])));
                checkOutput("rr_ready", 32'(req_ready), 32'(4'b0001 << exp_order[grants]));
                grants++;
                if (grants == 5) break;
            end
            if (busy) begin
                hold--;
                if (hold == 0) busy = 1'b0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    busy = 1'b1;
                    hold = 10;
                    dly  = -1;
                end
            end else if (transmit && dly < 0) begin
                dly = 2;
            end
        end
        checkOutput("rr_count", 32'(grants), 32'd5);
        applyStimulus(4'b0000, 1'b0);
        completeTxn("rr_end");

        // Busy held in IDLE blocks the grant.
        applyStimulus(4'b0100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bh_active", 32'(active),    32'd0);
            checkOutput("bh_ready",  32'(req_ready), 32'd0);
        end
        busy = 1'b0;
        tick();
        checkOutput("bh_ready_rel", 32'(req_ready), 32'(4'b0100));
        checkOutput("bh_id",        32'(grant_id),  32'd2);
        req_valid = 4'b0000;
        completeTxn("bh");

        // Wrap-around: serve 3 first so last_grant=3, then 0101 gives 0 then 2.
        req_valid = 4'b1000;
        waitGrant("wr_pre", 2'd3);
        req_valid = 4'b0000;
        completeTxn("wr_pre");
        req_valid = 4'b0101;
        waitGrant("wr_first", 2'd0);
        req_valid = 4'b0100;
        completeTxn("wr_first");
        waitGrant("wr_second", 2'd2);
        req_valid = 4'b0000;
        completeTxn("wr_second");

        // Mid-operation reset during SEND.
        req_valid = 4'b0010;
        waitGrant("mr_pre", 2'd1);
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("mr_send", 32'(active), 32'd1);
        rst = 1'b0;
        tick();
        checkOutput("mr_tx",     32'(transmit),  32'd0);
        checkOutput("mr_active", 32'(active),    32'd0);
        checkOutput("mr_ready",  32'(req_ready), 32'd0);
        busy = 1'b0;
        rst  = 1'b1;
        waitGrant("mr_post", 2'd0);
        req_valid = 4'b0000;
        completeTxn("mr_post");

`ifdef UART_ARB_TIMEOUT_EN
        begin
            int tx_cycles;
            int err_pulses;
            req_valid = 4'b0010;
            waitGrant("to_grant", 2'd1);
            req_valid  = 4'b0000;
            tx_cycles  = 1;
            err_pulses = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (timeout_err) err_pulses++;
                if (transmit) tx_cycles++;
                else break;
            end
            checkOutput("to_active", 32'(active), 32'd0);
            tick();
            if (timeout_err) err_pulses++;
            checkOutput("to_tx_cycles", 32'(tx_cycles),  32'd16);
            checkOutput("to_err_once",  32'(err_pulses), 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter D_WIDTH, default 8, character width.
REQ-003 SHALL have parameter TIMEOUT, default 65535, clk cycles allowed for busy to rise after transmit.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester character pending.
REQ-007 SHALL have port req_data  input  N_REQ*D_WIDTH  packed characters; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-008 SHALL have port req_ready  output  N_REQ  one-cycle accept pulse per requester.
REQ-009 SHALL have port TX_data  output  D_WIDTH  character presented to the transmitter.
REQ-010 SHALL have port transmit  output  1  start request to the transmitter.
REQ-011 SHALL have port busy  input  1  transmitter busy, synchronous to clk.
REQ-012 SHALL have port grant_id  output  clog2(N_REQ)  index of the requester being served.
REQ-013 SHALL have port active  output  1  high in any state other than IDLE.
REQ-014 SHALL have port timeout_err  output  1  one-cycle error pulse; present only with the macro in REQ-031.

Function
REQ-015 SHALL implement FSM states IDLE, START and SEND.
REQ-016 IDLE SHALL grant only when some req_valid bit is 1 and busy is 0.
- With busy=1 it SHALL stay in IDLE.
REQ-017 Grant selection SHALL be round-robin.
- Search starts at last_grant+1 and wraps modulo N_REQ.
- last_grant resets to N_REQ-1, so requester 0 wins first.
REQ-018 On a grant in cycle N:
- cycle N+1: state=START; TX_data = req_data of the winner sampled in cycle N; grant_id = winner; last_grant = winner.
- req_ready[winner]=1 for exactly cycle N+1; all other req_ready bits stay 0.
REQ-019 In START, transmit SHALL be 1.
- The cycle after busy is sampled 1, transmit SHALL be 0 and state SHALL be SEND.
REQ-020 In SEND, transmit SHALL be 0.
- The cycle after busy is sampled 0, state SHALL be IDLE.
REQ-021 TX_data and grant_id SHALL hold stable from grant until the return to IDLE.
REQ-022 req_valid and req_data SHALL be ignored outside IDLE.
REQ-023 A requester SHALL hold req_valid and req_data until it sees req_ready.
- A requester whose valid drops before grant is simply not served.
REQ-024 Minimum gap between consecutive grants SHALL be 1 IDLE cycle.
REQ-025 A single active requester SHALL be re-granted back-to-back.
REQ-026 active SHALL equal (state != IDLE).

Reset
REQ-027 While rst=0 at a clock edge, the block SHALL load:
- state=IDLE, transmit=0, req_ready=0, TX_data=0, grant_id=0, timeout_err=0, last_grant=N_REQ-1, timeout counter=0.
REQ-028 Reset asserted in START or SEND SHALL drop transmit on the next edge.
- No req_ready SHALL be issued after that edge.
- The interrupted character is not retried.

Configuration
REQ-029 With UART_ARB_TIMEOUT_EN defined:
- A counter SHALL clear on entry to START and increment each START cycle.
- When it reaches TIMEOUT with busy still 0, the next cycle SHALL have transmit=0, state=IDLE and timeout_err=1 for one cycle.
- last_grant is kept, so the next grant rotates past the failed requester.
REQ-030 Without UART_ARB_TIMEOUT_EN, START SHALL wait indefinitely.
- The timeout_err port and the counter SHALL be absent.
REQ-031 The macro name SHALL be exactly UART_ARB_TIMEOUT_EN.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum and the default N_REQ, D_WIDTH and TIMEOUT constants.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_arbiter.
- Inputs: req, last_grant. Outputs: any, winner.
- uart_tx_arbiter SHALL instantiate it once.

Verification
REQ-034 Reset scenario: hold rst=0 for 3 cycles with req_valid=4'b1111.
- Required: all outputs at reset values and no req_ready pulse.
REQ-035 Round-robin scenario: req_valid=4'b1111 with data 0x41/0x42/0x43/0x44; bench models busy rising 2 cycles after transmit and staying high for 10 cycles.
- Required: grants in order 0,1,2,3,0 and TX_data sequence 0x41,0x42,0x43,0x44,0x41.
REQ-036 Busy-hold scenario: busy=1 in IDLE with req_valid[2]=1.
- Required: no grant until busy=0, then grant_id=2 one cycle later.
REQ-037 Wrap-around scenario: last_grant=3; raise req_valid=4'b0101.
- Required: grant goes to requester 0, then to requester 2.
REQ-038 Mid-operation reset: assert rst=0 during SEND.
- Required: transmit=0 and state=IDLE on the next edge; after release, requester 0 is served first.
REQ-039 Timeout scenario (macro defined, TIMEOUT=16): busy held at 0 after a grant.
- Required: transmit high for 16 cycles, timeout_err pulses once, state returns to IDLE.
